// File: rtl/const_reg_pkg.sv
// Shared register-map constants, response codes and FSM state types for the
// constant-value read-back block and its AXI-Lite slave.
package const_reg_pkg;

    localparam int ADDR_CTRL   = 'h00;
    localparam int ADDR_STATUS = 'h04;
    localparam int ADDR_DATA0  = 'h08;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_SNAP_BIT = 0;
    localparam int CTRL_AUTO_BIT = 1;

    typedef enum logic {R_IDLE, R_RESP} rd_state_t;
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;

    function automatic int nwords_of(input int val_width);
        return (val_width + 31) / 32;
    endfunction

endpackage

// File: rtl/axilite_slave_fsm.sv
// AXI-Lite slave handshake engine: independent read and write FSMs that turn
// bus transactions into single-cycle reg_wr / reg_rd strobes for the owner.
module axilite_slave_fsm
    import const_reg_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  s_axilite_AWVALID,
    output logic                  s_axilite_AWREADY,
    input  logic [ADDR_WIDTH-1:0] s_axilite_AWADDR,
    input  logic                  s_axilite_WVALID,
    output logic                  s_axilite_WREADY,
    input  logic [31:0]           s_axilite_WDATA,
    input  logic [3:0]            s_axilite_WSTRB,
    output logic                  s_axilite_BVALID,
    input  logic                  s_axilite_BREADY,
    output logic [1:0]            s_axilite_BRESP,
    input  logic                  s_axilite_ARVALID,
    output logic                  s_axilite_ARREADY,
    input  logic [ADDR_WIDTH-1:0] s_axilite_ARADDR,
    output logic                  s_axilite_RVALID,
    input  logic                  s_axilite_RREADY,
    output logic [31:0]           s_axilite_RDATA,
    output logic [1:0]            s_axilite_RRESP,
    output logic                  reg_wr,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [31:0]           reg_wr_data,
    output logic [3:0]            reg_wr_strb,
    input  logic [1:0]            wr_resp,
    output logic                  reg_rd,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic [31:0]           rd_data,
    input  logic [1:0]            rd_resp
);

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;
    logic [1:0]            bresp_q;
    logic [31:0]           rdata_q;
    logic [1:0]            rresp_q;
    logic                  aw_hs, w_hs;

    assign s_axilite_AWREADY = (w_state == W_IDLE) && !aw_held;
    assign s_axilite_WREADY  = (w_state == W_IDLE) && !w_held;
    assign s_axilite_BVALID  = (w_state == W_RESP);
    assign s_axilite_BRESP   = bresp_q;

    assign aw_hs = s_axilite_AWVALID && s_axilite_AWREADY;
    assign w_hs  = s_axilite_WVALID && s_axilite_WREADY;

    // A half arriving this cycle is forwarded directly so a same-cycle AW+W
    // commits without waiting for the held copies.
    assign reg_wr      = (aw_held || aw_hs) && (w_held || w_hs);
    assign reg_wr_addr = aw_held ? aw_addr_q : s_axilite_AWADDR;
    assign reg_wr_data = w_held ? w_data_q : s_axilite_WDATA;
    assign reg_wr_strb = w_held ? w_strb_q : s_axilite_WSTRB;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (reg_wr) w_next = W_RESP;
            W_RESP:  if (s_axilite_BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else if (reg_wr) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= wr_resp;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axilite_AWADDR;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_axilite_WDATA;
                w_strb_q <= s_axilite_WSTRB;
            end
        end
    end

    assign s_axilite_ARREADY = (r_state == R_IDLE);
    assign s_axilite_RVALID  = (r_state == R_RESP);
    assign s_axilite_RDATA   = rdata_q;
    assign s_axilite_RRESP   = rresp_q;
    assign reg_rd            = s_axilite_ARVALID && s_axilite_ARREADY;
    assign reg_rd_addr       = s_axilite_ARADDR;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (reg_rd) r_next = R_RESP;
            R_RESP:  if (s_axilite_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (reg_rd) begin
            rdata_q <= rd_data;
            rresp_q <= rd_resp;
        end
    end

endmodule

// File: rtl/const_value_reader.sv
// Samples a constant/config value bus into a shadow register and exposes it
// over AXI-Lite, with a word-0 latch so multi-word values read coherently.
module const_value_reader
    import const_reg_pkg::*;
#(
    parameter int   VAL_WIDTH    = 10,
    parameter int   ADDR_WIDTH   = 9,
    parameter logic AUTO_DEFAULT = 1'b1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [VAL_WIDTH-1:0]  din,
    input  logic                  s_axilite_AWVALID,
    output logic                  s_axilite_AWREADY,
    input  logic [ADDR_WIDTH-1:0] s_axilite_AWADDR,
    input  logic                  s_axilite_WVALID,
    output logic                  s_axilite_WREADY,
    input  logic [31:0]           s_axilite_WDATA,
    input  logic [3:0]            s_axilite_WSTRB,
    output logic                  s_axilite_BVALID,
    input  logic                  s_axilite_BREADY,
    output logic [1:0]            s_axilite_BRESP,
    input  logic                  s_axilite_ARVALID,
    output logic                  s_axilite_ARREADY,
    input  logic [ADDR_WIDTH-1:0] s_axilite_ARADDR,
    output logic                  s_axilite_RVALID,
    input  logic                  s_axilite_RREADY,
    output logic [31:0]           s_axilite_RDATA,
    output logic [1:0]            s_axilite_RRESP
);

    localparam int NWORDS      = nwords_of(VAL_WIDTH);
    localparam int IDXW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int LOW_BITS    = (VAL_WIDTH < 32) ? VAL_WIDTH : 32;
    localparam int CTRL_WORD   = ADDR_CTRL / 4;
    localparam int STATUS_WORD = ADDR_STATUS / 4;
    localparam int DATA0_WORD  = ADDR_DATA0 / 4;

    logic                  reg_wr, reg_rd;
    logic [ADDR_WIDTH-1:0] reg_wr_addr, reg_rd_addr;
    logic [31:0]           reg_wr_data, rd_data;
    logic [3:0]            reg_wr_strb;
    logic [1:0]            wr_resp, rd_resp;

    logic                  ctrl_auto, snap_pulse, data_valid;
    logic                  wr_is_ctrl, ctrl_wr, capture;
    logic [VAL_WIDTH-1:0]  shadow, hold;
    logic [NWORDS*32-1:0]  hold_ext;
    logic [31:0]           shadow_lo;
    logic [31:0]           data_words [NWORDS];
    int                    rd_word;
    logic [IDXW-1:0]       rd_idx;
    logic                  unused_bits;

    axilite_slave_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_fsm (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .s_axilite_AWVALID (s_axilite_AWVALID),
        .s_axilite_AWREADY (s_axilite_AWREADY),
        .s_axilite_AWADDR  (s_axilite_AWADDR),
        .s_axilite_WVALID  (s_axilite_WVALID),
        .s_axilite_WREADY  (s_axilite_WREADY),
        .s_axilite_WDATA   (s_axilite_WDATA),
        .s_axilite_WSTRB   (s_axilite_WSTRB),
        .s_axilite_BVALID  (s_axilite_BVALID),
        .s_axilite_BREADY  (s_axilite_BREADY),
        .s_axilite_BRESP   (s_axilite_BRESP),
        .s_axilite_ARVALID (s_axilite_ARVALID),
        .s_axilite_ARREADY (s_axilite_ARREADY),
        .s_axilite_ARADDR  (s_axilite_ARADDR),
        .s_axilite_RVALID  (s_axilite_RVALID),
        .s_axilite_RREADY  (s_axilite_RREADY),
        .s_axilite_RDATA   (s_axilite_RDATA),
        .s_axilite_RRESP   (s_axilite_RRESP),
        .reg_wr            (reg_wr),
        .reg_wr_addr       (reg_wr_addr),
        .reg_wr_data       (reg_wr_data),
        .reg_wr_strb       (reg_wr_strb),
        .wr_resp           (wr_resp),
        .reg_rd            (reg_rd),
        .reg_rd_addr       (reg_rd_addr),
        .rd_data           (rd_data),
        .rd_resp           (rd_resp)
    );

    assign wr_is_ctrl = (int'(reg_wr_addr >> 2) == CTRL_WORD);
    assign wr_resp    = wr_is_ctrl ? RESP_OKAY : RESP_SLVERR;
    assign ctrl_wr    = reg_wr && wr_is_ctrl && reg_wr_strb[0];
    assign capture    = ctrl_auto || snap_pulse;

    // Snap is delayed one cycle so the capture lands in the cycle after the
    // CTRL write commits; an auto capture in that cycle is the same sample.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ctrl_auto  <= AUTO_DEFAULT;
            snap_pulse <= 1'b0;
        end else begin
            snap_pulse <= ctrl_wr && reg_wr_data[CTRL_SNAP_BIT];
            if (ctrl_wr) ctrl_auto <= reg_wr_data[CTRL_AUTO_BIT];
        end
    end

    // hold copies the pre-capture shadow, so a DATA0 read racing a capture
    // still returns a matching word set.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            shadow     <= '0;
            hold       <= '0;
            data_valid <= 1'b0;
        end else begin
            if (capture) begin
                shadow     <= din;
                data_valid <= 1'b1;
            end
            if (reg_rd && int'(reg_rd_addr >> 2) == DATA0_WORD) hold <= shadow;
        end
    end

    always_comb begin
        shadow_lo = '0;
        shadow_lo[LOW_BITS-1:0] = shadow[LOW_BITS-1:0];
        hold_ext = '0;
        hold_ext[VAL_WIDTH-1:0] = hold;
    end

    genvar g;
    generate
        for (g = 0; g < NWORDS; g++) begin : g_words
            if (g == 0) begin : g_lo
                assign data_words[g] = shadow_lo;
            end else begin : g_hi
                assign data_words[g] = hold_ext[g*32 +: 32];
            end
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        rd_idx  = '0;
        rd_word = int'(reg_rd_addr >> 2);
        if (rd_word == CTRL_WORD) begin
            rd_data[CTRL_AUTO_BIT] = ctrl_auto;
        end else if (rd_word == STATUS_WORD) begin
            rd_data = {16'(VAL_WIDTH), 15'd0, data_valid};
        end else if (rd_word >= DATA0_WORD && rd_word < DATA0_WORD + NWORDS) begin
            rd_idx  = IDXW'(rd_word - DATA0_WORD);
            rd_data = data_words[rd_idx];
        end else begin
            rd_resp = RESP_SLVERR;
        end
    end

    assign unused_bits = ^{hold_ext[31:0], reg_wr_data[31:2], reg_wr_strb[3:1]};

endmodule

// File: tb/tb_const_value_reader.sv
// Bench for const_value_reader: a 10-bit and a 40-bit instance share one AXI-Lite
// input bus; a transaction-level model is checked every cycle, plus literal checks.
module tb_const_value_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  din_a;
    logic [39:0] din_b;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [8:0]  awaddr, araddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic [1:0]  awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp [2];
    logic [1:0]  rresp [2];
    logic [31:0] rdata [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    const_value_reader #(.VAL_WIDTH(10), .ADDR_WIDTH(9), .AUTO_DEFAULT(1'b1)) dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .din(din_a),
        .s_axilite_AWVALID(awvalid), .s_axilite_AWREADY(awready[0]), .s_axilite_AWADDR(awaddr),
        .s_axilite_WVALID(wvalid), .s_axilite_WREADY(wready[0]), .s_axilite_WDATA(wdata),
        .s_axilite_WSTRB(wstrb), .s_axilite_BVALID(bvalid[0]), .s_axilite_BREADY(bready),
        .s_axilite_BRESP(bresp[0]), .s_axilite_ARVALID(arvalid), .s_axilite_ARREADY(arready[0]),
        .s_axilite_ARADDR(araddr), .s_axilite_RVALID(rvalid[0]), .s_axilite_RREADY(rready),
        .s_axilite_RDATA(rdata[0]), .s_axilite_RRESP(rresp[0])
    );

    const_value_reader #(.VAL_WIDTH(40), .ADDR_WIDTH(9), .AUTO_DEFAULT(1'b1)) dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .din(din_b),
        .s_axilite_AWVALID(awvalid), .s_axilite_AWREADY(awready[1]), .s_axilite_AWADDR(awaddr),
        .s_axilite_WVALID(wvalid), .s_axilite_WREADY(wready[1]), .s_axilite_WDATA(wdata),
        .s_axilite_WSTRB(wstrb), .s_axilite_BVALID(bvalid[1]), .s_axilite_BREADY(bready),
        .s_axilite_BRESP(bresp[1]), .s_axilite_ARVALID(arvalid), .s_axilite_ARREADY(arready[1]),
        .s_axilite_ARADDR(araddr), .s_axilite_RVALID(rvalid[1]), .s_axilite_RREADY(rready),
        .s_axilite_RDATA(rdata[1]), .s_axilite_RRESP(rresp[1])
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          widths [2] = '{10, 40};
    logic        m_auto, m_snap_pend, m_valid;
    logic [63:0] m_shadow [2];
    logic [63:0] m_hold [2];
    bit          m_r_busy, m_b_busy, m_aw_have, m_w_have;
    logic [31:0] m_rdata [2];
    logic [1:0]  m_rresp [2];
    logic [8:0]  m_awaddr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp;

    // bit 32 flags an out-of-range register
    function automatic logic [32:0] model_reg(input int i, input int word);
        int nw = (widths[i] + 31) / 32;
        logic [63:0] src;
        if (word == 0) return {31'd0, m_auto, 1'b0};
        if (word == 1) return (33'(widths[i]) << 16) | 33'(m_valid);
        if (word >= 2 && word < 2 + nw) begin
            src = (word == 2) ? m_shadow[i] : m_hold[i];
            return {1'b0, 32'(src >> (32 * (word - 2)))};
        end
        return {1'b1, 32'h0};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic cap, auto_n, snap_n;
        logic [32:0] r;
        int word;
        if (!rst_n) begin
            m_auto = 1'b1; m_snap_pend = 1'b0; m_valid = 1'b0;
            m_r_busy = 0; m_b_busy = 0; m_aw_have = 0; m_w_have = 0;
            m_awaddr = '0; m_wdata = '0; m_wstrb = '0; m_bresp = 2'b00;
            for (int i = 0; i < 2; i++) begin
                m_shadow[i] = '0; m_hold[i] = '0; m_rdata[i] = '0; m_rresp[i] = 2'b00;
            end
        end else begin
            cap    = m_auto || m_snap_pend;
            auto_n = m_auto;
            snap_n = 1'b0;
            if (m_r_busy) begin
                if (rready) m_r_busy = 0;
            end else if (arvalid) begin
                word = int'(araddr >> 2);
                for (int i = 0; i < 2; i++) begin
                    r = model_reg(i, word);
                    m_rdata[i] = r[31:0];
                    m_rresp[i] = r[32] ? 2'b10 : 2'b00;
                    if (word == 2) m_hold[i] = m_shadow[i];
                end
                m_r_busy = 1;
            end
            if (m_b_busy) begin
                if (bready) m_b_busy = 0;
            end else begin
                if (awvalid && !m_aw_have) begin m_aw_have = 1; m_awaddr = awaddr; end
                if (wvalid && !m_w_have) begin m_w_have = 1; m_wdata = wdata; m_wstrb = wstrb; end
                if (m_aw_have && m_w_have) begin
                    m_aw_have = 0; m_w_have = 0; m_b_busy = 1;
                    if ((m_awaddr >> 2) == 0) begin
                        m_bresp = 2'b00;
                        if (m_wstrb[0]) begin auto_n = m_wdata[1]; snap_n = m_wdata[0]; end
                    end else begin
                        m_bresp = 2'b10;
                    end
                end
            end
            if (cap) begin
                m_shadow[0] = 64'(din_a);
                m_shadow[1] = 64'(din_b);
                m_valid = 1'b1;
            end
            m_auto      = auto_n;
            m_snap_pend = snap_n;
        end
    end

    // Every cycle: handshake outputs of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check_output($sformatf("awready%0d", i), 32'(awready[i]), 32'(!m_b_busy && !m_aw_have));
            check_output($sformatf("wready%0d", i), 32'(wready[i]), 32'(!m_b_busy && !m_w_have));
            check_output($sformatf("bvalid%0d", i), 32'(bvalid[i]), 32'(m_b_busy));
            check_output($sformatf("arready%0d", i), 32'(arready[i]), 32'(!m_r_busy));
            check_output($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'(m_r_busy));
            if (m_b_busy) check_output($sformatf("bresp%0d", i), 32'(bresp[i]), 32'(m_bresp));
            if (m_r_busy) begin
                check_output($sformatf("rdata%0d", i), rdata[i], m_rdata[i]);
                check_output($sformatf("rresp%0d", i), 32'(rresp[i]), 32'(m_rresp[i]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ar(output bit hs);
        int n = 0;
        hs = 0;
        while (!hs && n < 20) begin
            hs = arready[0];
            @(negedge clk);
            n++;
        end
        arvalid = 1'b0;
        if (!hs) check_output("ar_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_read(input logic [8:0] addr, output logic [31:0] d0, output logic [31:0] d1,
                              output logic [1:0] r0, output logic [1:0] r1);
        bit hs;
        int n = 0;
        d0 = '0; d1 = '0; r0 = 2'b11; r1 = 2'b11;
        arvalid = 1'b1; araddr = addr; rready = 1'b1;
        wait_ar(hs);
        while (hs && !rvalid[0] && n < 20) begin @(negedge clk); n++; end
        if (hs && !rvalid[0]) check_output("r_timeout", 32'd0, 32'd1);
        if (hs && rvalid[0]) begin
            d0 = rdata[0]; d1 = rdata[1]; r0 = rresp[0]; r1 = rresp[1];
            @(negedge clk);
        end
    endtask

    task automatic apply_stimulus(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                  input int aw_delay, output logic [1:0] resp, output int nb);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int cyc = 0;
        resp = 2'b11; nb = 0; bready = 1'b1;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_delay); awaddr = addr;
            wvalid  = !w_done; wdata = data; wstrb = strb;
            hs_aw = awvalid && awready[0];
            hs_w  = wvalid && wready[0];
            @(negedge clk);
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) check_output("w_timeout", 32'd0, 32'd1);
        for (int c = 0; c < 6; c++) begin
            if (bvalid[0]) begin nb++; resp = bresp[0]; end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] d0, d1;
        logic [1:0]  r0, r1, resp;
        int nb;
        bit hs;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        din_a = 10'd10; din_b = 40'h12_3456_789A;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        apply_read(9'h004, d0, d1, r0, r1);
        check_output("status_a", d0, 32'h000A0001);
        check_output("status_b", d1, 32'h00280001);
        apply_read(9'h008, d0, d1, r0, r1);
        check_output("data0_a", d0, 32'h0000000A);
        check_output("data0_a_resp", 32'(r0), 32'd0);
        check_output("data0_b", d1, 32'h3456789A);

        din_b = 40'hFF_0000_0000;
        repeat (2) @(negedge clk);
        apply_read(9'h00C, d0, d1, r0, r1);
        check_output("data1_b_atomic", d1, 32'h00000012);
        check_output("data1_a_resp", 32'(r0), 32'd2);
        apply_read(9'h008, d0, d1, r0, r1);
        check_output("data0_b_new", d1, 32'h00000000);
        apply_read(9'h00C, d0, d1, r0, r1);
        check_output("data1_b_new", d1, 32'h000000FF);

        apply_stimulus(9'h000, 32'h0, 4'hF, 0, resp, nb);
        check_output("ctrl_off_bresp", 32'(resp), 32'd0);
        din_a = 10'd5;
        repeat (2) @(negedge clk);
        apply_read(9'h008, d0, d1, r0, r1);
        check_output("auto_off_data0", d0, 32'h0000000A);
        apply_read(9'h000, d0, d1, r0, r1);
        check_output("ctrl_off", d0, 32'h0);
        apply_stimulus(9'h000, 32'h1, 4'hF, 0, resp, nb);
        repeat (2) @(negedge clk);
        apply_read(9'h008, d0, d1, r0, r1);
        check_output("snap_data0", d0, 32'h00000005);

        apply_stimulus(9'h000, 32'h2, 4'hF, 3, resp, nb);
        check_output("w_first_nb", 32'(nb), 32'd1);
        check_output("w_first_bresp", 32'(resp), 32'd0);
        apply_read(9'h000, d0, d1, r0, r1);
        check_output("ctrl_auto_on", d0, 32'h2);

        arvalid = 1'b1; araddr = 9'h004; rready = 1'b0;
        wait_ar(hs);
        for (int c = 0; c < 5; c++) begin
            check_output("stall_rvalid", 32'(rvalid[0]), 32'd1);
            check_output("stall_rdata", rdata[0], 32'h000A0001);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        check_output("stall_done", 32'(rvalid[0]), 32'd0);

        apply_read(9'h040, d0, d1, r0, r1);
        check_output("oor_data", d0, 32'h0);
        check_output("oor_resp", 32'(r0), 32'd2);
        check_output("oor_resp_b", 32'(r1), 32'd2);

        apply_stimulus(9'h000, 32'h0, 4'hF, 0, resp, nb);
        din_a = 10'd7;
        repeat (2) @(negedge clk);
        apply_stimulus(9'h008, 32'h1, 4'hF, 0, resp, nb);
        check_output("bad_wr_bresp", 32'(resp), 32'd2);
        repeat (2) @(negedge clk);
        apply_read(9'h008, d0, d1, r0, r1);
        check_output("bad_wr_shadow", d0, 32'h00000005);

        arvalid = 1'b1; araddr = 9'h004; rready = 1'b0;
        wait_ar(hs);
        check_output("pre_rst_rvalid", 32'(rvalid[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_output("rst_rvalid", 32'(rvalid[0]), 32'd0);
        check_output("rst_rvalid_b", 32'(rvalid[1]), 32'd0);
        rready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post_rst_arready", 32'(arready[0]), 32'd1);
        apply_read(9'h004, d0, d1, r0, r1);
        check_output("post_rst_status", d0, 32'h000A0001);
        apply_read(9'h000, d0, d1, r0, r1);
        check_output("post_rst_ctrl", d0, 32'h2);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/const_value_reader.md
Name: const_value_reader

Overview:
- Host-side read-back for constant and configuration sources: samples a VAL_WIDTH-wide value bus, for example a constant block's dout, into a shadow register.
- The shadow register is exposed over an AXI-Lite slave, so the driver can verify the constants baked into a stitched accelerator.
- Multi-word values are read coherently through a word-0 latch.
- Sits beside the constant sources inside the accelerator's AXI-Lite control interconnect.

Parameters:
- VAL_WIDTH, 10, width of sampled value (1..2048)
- ADDR_WIDTH, 9, AXI-Lite byte-address width; must cover 0x08 + 4*NWORDS
- AUTO_DEFAULT, 1, reset value of CTRL.auto
- Derived localparam NWORDS = ceil(VAL_WIDTH/32)

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- din  in  VAL_WIDTH  value to sample; synchronous to ap_clk
- s_axilite_AWVALID  in  1  write address valid
- s_axilite_AWREADY  out  1  write address ready
- s_axilite_AWADDR  in  ADDR_WIDTH  write byte address
- s_axilite_WVALID  in  1  write data valid
- s_axilite_WREADY  out  1  write data ready
- s_axilite_WDATA  in  32  write data
- s_axilite_WSTRB  in  4  write strobes
- s_axilite_BVALID  out  1  write response valid
- s_axilite_BREADY  in  1  write response ready
- s_axilite_BRESP  out  2  write response
- s_axilite_ARVALID  in  1  read address valid
- s_axilite_ARREADY  out  1  read address ready
- s_axilite_ARADDR  in  ADDR_WIDTH  read byte address
- s_axilite_RVALID  out  1  read data valid
- s_axilite_RREADY  in  1  read data ready
- s_axilite_RDATA  out  32  read data
- s_axilite_RRESP  out  2  read response

Behaviour:
- Reset (async assert, sync deassert):
  - Outputs: AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0.
  - Internal: shadow=0, hold=0, CTRL.auto=AUTO_DEFAULT, STATUS.valid=0.
- Register map (word-aligned; ARADDR[1:0] ignored):
  - 0x00 CTRL, RW. bit0 snap: write-1 is a one-cycle pulse and reads 0. bit1 auto.
  - 0x04 STATUS, RO. bit0 valid. bits[31:16] = VAL_WIDTH.
  - 0x08+4k DATA[k], RO, k=0..NWORDS-1: bits [32k+31:32k] of the value, little-endian word order; bits above VAL_WIDTH read 0.
- Capture:
  - shadow <= din every cycle while auto=1, and in the cycle after the CTRL write handshake when snap=1.
  - Either capture sets valid=1. valid is cleared only by reset.
  - Snap and auto in the same cycle: one capture of the same din; no conflict.
- Coherence:
  - A read of DATA[0] copies shadow to hold in the AR handshake cycle; RDATA returns shadow[31:0] from that copy.
  - Reads of DATA[k>0] return hold, so a 0..N-1 word sequence is atomic.
  - Reading DATA[k>0] without a prior DATA[0] read returns the stale hold (0 after reset).
- Read FSM, states R_IDLE / R_RESP:
  - R_IDLE: ARREADY=1. An ARVALID handshake registers RDATA/RRESP and moves to R_RESP.
  - R_RESP: ARREADY=0, RVALID=1, RDATA stable until RREADY, then back to R_IDLE.
  - Latency: RVALID is asserted in the cycle after the AR handshake; maximum throughput is one read per 2 cycles.
- Write FSM, states W_IDLE / W_RESP:
  - AW and W are accepted independently in any order. Each ready drops after its own handshake.
  - Once both are held, CTRL is updated if address=0x00 and WSTRB[0]=1, and the FSM moves to W_RESP with BVALID=1.
  - BREADY returns the FSM to W_IDLE with both readies raised.
  - Same-cycle AW+W is accepted in that cycle; BVALID follows in the next cycle.
- Responses:
  - Out-of-range read returns RDATA=0, RRESP=2'b10 (SLVERR).
  - Write to any address other than 0x00 is ignored with BRESP=2'b10. Otherwise the response is 2'b00.
- Concurrency: the read and write channels are independent. A capture in the same cycle as a DATA[0] AR handshake: hold takes the pre-capture shadow.
- Reset mid-transaction: the FSMs return to idle immediately, with no completion of the outstanding response.

Decomposition:
- Shared package const_reg_pkg:
  - register offsets ADDR_CTRL=0x00, ADDR_STATUS=0x04, ADDR_DATA0=0x08
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - CTRL bit indices
- One sub-module is natural: axilite_slave_fsm, holding both handshake FSMs and exposing a simple reg_wr/reg_rd strobe interface. Capture, hold and the register mux stay in the top.

Test Plan:
- Reset, VAL_WIDTH=10, din=10'd10:
  - read 0x04 -> 0x000A0001 (auto captured)
  - read 0x08 -> 0x0000000A, RRESP=0
- auto=0:
  - write 0x00=0x0 with din=10'd10, then set din=10'd5; read 0x08 -> 0x0000000A
  - write 0x00=0x1, then read 0x08 -> 0x00000005
- VAL_WIDTH=40, din=40'h12_3456_789A:
  - read 0x08 -> 0x3456789A
  - change din to 40'hFF_0000_0000, then read 0x0C -> 0x00000012 (atomic hold)
- Handshake:
  - W before AW with a 3-cycle gap -> single BVALID, CTRL updated once
  - RREADY held low 5 cycles -> RDATA stable and RVALID high throughout
- Error paths:
  - read 0x40 (beyond NWORDS) -> RDATA=0, RRESP=2'b10
  - write 0x08 -> BRESP=2'b10, shadow unchanged
- ap_rst_n pulsed low while RVALID=1 -> RVALID=0 asynchronously; after release ARREADY=1 and valid reflects auto=AUTO_DEFAULT.
